// File: rtl/pipe_decoder.sv
// rtl/pipe_decoder.sv - single registered decode stage with load-use bubble and stall counter
module pipe_decoder #(
    parameter int INSTR_W     = 32,
    parameter int OPC_W       = 7,
    parameter int RA_W        = 5,
    parameter int LOAD_USE_EN = 1,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               RW,
    output logic               MW,
    output logic               PS,
    output logic               MA,
    output logic               MB,
    output logic               CS,
    output logic [1:0]         MD,
    output logic [1:0]         BS,
    output logic [4:0]         FS,
    output logic [RA_W-1:0]    DA,
    output logic [RA_W-1:0]    AA,
    output logic [RA_W-1:0]    BA,
    output logic               out_illegal,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int DR_HI = INSTR_W - OPC_W - 1;
    localparam int SA_HI = DR_HI - RA_W;
    localparam int SB_HI = SA_HI - RA_W;

    localparam logic [OPC_W-1:0] OP_NOP = OPC_W'(7'b0000000);
    localparam logic [OPC_W-1:0] OP_MOV = OPC_W'(7'b1000000);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(7'b0000010);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(7'b0000101);
    localparam logic [OPC_W-1:0] OP_AND = OPC_W'(7'b0001000);
    localparam logic [OPC_W-1:0] OP_OR  = OPC_W'(7'b0001001);
    localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(7'b0001010);
    localparam logic [OPC_W-1:0] OP_NOT = OPC_W'(7'b0001011);
    localparam logic [OPC_W-1:0] OP_ADI = OPC_W'(7'b0100010);
    localparam logic [OPC_W-1:0] OP_SBI = OPC_W'(7'b0100101);
    localparam logic [OPC_W-1:0] OP_ANI = OPC_W'(7'b0101000);
    localparam logic [OPC_W-1:0] OP_ORI = OPC_W'(7'b0101001);
    localparam logic [OPC_W-1:0] OP_XRI = OPC_W'(7'b0101010);
    localparam logic [OPC_W-1:0] OP_AIU = OPC_W'(7'b1000010);
    localparam logic [OPC_W-1:0] OP_SIU = OPC_W'(7'b1000101);
    localparam logic [OPC_W-1:0] OP_LSL = OPC_W'(7'b0001100);
    localparam logic [OPC_W-1:0] OP_LSR = OPC_W'(7'b0001101);
    localparam logic [OPC_W-1:0] OP_LOD = OPC_W'(7'b0010000);
    localparam logic [OPC_W-1:0] OP_ST  = OPC_W'(7'b0100000);
    localparam logic [OPC_W-1:0] OP_JMR = OPC_W'(7'b1110000);
    localparam logic [OPC_W-1:0] OP_SLT = OPC_W'(7'b1100101);
    localparam logic [OPC_W-1:0] OP_BZ  = OPC_W'(7'b1100000);
    localparam logic [OPC_W-1:0] OP_BNZ = OPC_W'(7'b1001000);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(7'b1000100);
    localparam logic [OPC_W-1:0] OP_JML = OPC_W'(7'b0000111);

    typedef struct packed {
        logic       rw;
        logic [1:0] md;
        logic [1:0] bs;
        logic       ps;
        logic       mw;
        logic [4:0] fs;
        logic       mb;
        logic       ma;
        logic       cs;
        logic       illegal;
    } ctl_t;

    logic [OPC_W-1:0]   opc;
    logic [RA_W-1:0]    dr_in;
    logic [RA_W-1:0]    sa_in;
    logic [RA_W-1:0]    sb_in;
    logic [INSTR_W-1:0] unused_instr;

    ctl_t               dec;
    logic               has_regs;
    ctl_t               ctl_q;
    logic               valid_q;
    logic [RA_W-1:0]    da_q;
    logic [RA_W-1:0]    aa_q;
    logic [RA_W-1:0]    ba_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               hz;
    logic               accept;

    // Bits below SB carry immediates consumed elsewhere in the pipe.
    assign unused_instr = in_instr;
    assign opc   = in_instr[INSTR_W-1 -: OPC_W];
    assign dr_in = in_instr[DR_HI -: RA_W];
    assign sa_in = in_instr[SA_HI -: RA_W];
    assign sb_in = in_instr[SB_HI -: RA_W];

    always_comb begin
        dec      = '0;
        has_regs = 1'b1;
        case (opc)
            OP_NOP: has_regs = 1'b0;
            OP_MOV: dec.rw = 1'b1;
            OP_ADD: begin dec.rw = 1'b1; dec.fs = 5'b00010; end
            OP_SUB: begin dec.rw = 1'b1; dec.fs = 5'b00101; end
            OP_AND: begin dec.rw = 1'b1; dec.fs = 5'b01000; end
            OP_OR:  begin dec.rw = 1'b1; dec.fs = 5'b01010; end
            OP_XOR: begin dec.rw = 1'b1; dec.fs = 5'b01100; end
            OP_NOT: begin dec.rw = 1'b1; dec.fs = 5'b01110; end
            OP_ADI: begin dec.rw = 1'b1; dec.fs = 5'b00010; dec.mb = 1'b1; dec.cs = 1'b1; end
            OP_SBI: begin dec.rw = 1'b1; dec.fs = 5'b00101; dec.mb = 1'b1; dec.cs = 1'b1; end
            OP_ANI: begin dec.rw = 1'b1; dec.fs = 5'b01000; dec.mb = 1'b1; end
            OP_ORI: begin dec.rw = 1'b1; dec.fs = 5'b01010; dec.mb = 1'b1; end
            OP_XRI: begin dec.rw = 1'b1; dec.fs = 5'b01100; dec.mb = 1'b1; end
            OP_AIU: begin dec.rw = 1'b1; dec.fs = 5'b00010; dec.mb = 1'b1; end
            OP_SIU: begin dec.rw = 1'b1; dec.fs = 5'b00101; dec.mb = 1'b1; end
            OP_LSL: begin dec.rw = 1'b1; dec.fs = 5'b11000; end
            OP_LSR: begin dec.rw = 1'b1; dec.fs = 5'b10100; end
            OP_LOD: begin dec.rw = 1'b1; dec.md = 2'b01; end
            OP_ST:  dec.mw = 1'b1;
            OP_JMR: dec.bs = 2'b10;
            OP_SLT: begin dec.rw = 1'b1; dec.md = 2'b10; dec.fs = 5'b00101; end
            OP_BZ:  begin dec.bs = 2'b01; dec.mb = 1'b1; dec.cs = 1'b1; end
            OP_BNZ: begin dec.bs = 2'b01; dec.ps = 1'b1; dec.mb = 1'b1; dec.cs = 1'b1; end
            OP_JMP: begin dec.bs = 2'b11; dec.mb = 1'b1; dec.cs = 1'b1; end
            OP_JML: begin
                dec.rw = 1'b1; dec.bs = 2'b11; dec.fs = 5'b00111;
                dec.ma = 1'b1; dec.mb = 1'b1; dec.cs = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
                has_regs    = 1'b0;
            end
        endcase
    end

    // A held load whose destination feeds the incoming instruction needs one bubble.
    assign hz = (LOAD_USE_EN != 0) && valid_q && (ctl_q.md == 2'b01) && (da_q != '0)
                && in_valid && ((sa_in == da_q) || (sb_in == da_q));

    assign in_ready = !RESET && !flush && !hz && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (RESET) begin
            valid_q <= 1'b0;
            ctl_q   <= '0;
            da_q    <= '0;
            aa_q    <= '0;
            ba_q    <= '0;
            cnt_q   <= '0;
        end else begin
            if (hz && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
                ctl_q   <= dec;
                da_q    <= has_regs ? dr_in : '0;
                aa_q    <= has_regs ? sa_in : '0;
                ba_q    <= has_regs ? sb_in : '0;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = valid_q;
    assign RW          = ctl_q.rw;
    assign MW          = ctl_q.mw;
    assign PS          = ctl_q.ps;
    assign MA          = ctl_q.ma;
    assign MB          = ctl_q.mb;
    assign CS          = ctl_q.cs;
    assign MD          = ctl_q.md;
    assign BS          = ctl_q.bs;
    assign FS          = ctl_q.fs;
    assign DA          = da_q;
    assign AA          = aa_q;
    assign BA          = ba_q;
    assign out_illegal = ctl_q.illegal;
    assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_decoder.sv
// tb/tb_pipe_decoder.sv - self-checking bench for pipe_decoder against an opcode-table model
module tb_pipe_decoder;

    logic        clk = 1'b0;
    logic        RESET, in_valid, flush, out_ready;
    logic [31:0] in_instr;
    logic        in_ready, out_valid, RW, MW, PS, MA, MB, CS, out_illegal;
    logic [1:0]  MD, BS;
    logic [4:0]  FS, DA, AA, BA;
    logic [15:0] stall_cnt;

    logic        s_in_ready, s_out_valid, s_RW, s_MW, s_PS, s_MA, s_MB, s_CS, s_out_illegal;
    logic [1:0]  s_MD, s_BS;
    logic [4:0]  s_FS, s_DA, s_AA, s_BA;
    logic [1:0]  s_stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_decoder dut (
        .clk(clk), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .RW(RW), .MW(MW), .PS(PS), .MA(MA), .MB(MB), .CS(CS), .MD(MD), .BS(BS), .FS(FS),
        .DA(DA), .AA(AA), .BA(BA), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
    );

    pipe_decoder #(.CNT_W(2)) dut_sat (
        .clk(clk), .RESET(RESET), .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr),
        .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
        .RW(s_RW), .MW(s_MW), .PS(s_PS), .MA(s_MA), .MB(s_MB), .CS(s_CS), .MD(s_MD), .BS(s_BS),
        .FS(s_FS), .DA(s_DA), .AA(s_AA), .BA(s_BA), .out_illegal(s_out_illegal),
        .stall_cnt(s_stall_cnt)
    );

    typedef struct packed {
        logic       valid, illegal, rw, mw, ps, ma, mb, cs;
        logic [1:0] md, bs;
        logic [4:0] fs, da, aa, ba;
    } word_t;

    // Control word per opcode, packed {rw, md, bs, ps, mw, fs, mb, ma, cs}.
    logic [14:0] cw_tab [logic [6:0]];
    logic [6:0]  op_of  [string];
    logic [6:0]  ops    [$];

    task automatic add_op(input string name, input logic [6:0] op, input logic [14:0] cw);
        cw_tab[op] = cw;
        op_of[name] = op;
        ops.push_back(op);
    endtask

    task automatic build_table();
        add_op("NOP", 7'b0000000, 15'b0_00_00_0_0_00000_0_0_0);
        add_op("MOV", 7'b1000000, 15'b1_00_00_0_0_00000_0_0_0);
        add_op("ADD", 7'b0000010, 15'b1_00_00_0_0_00010_0_0_0);
        add_op("SUB", 7'b0000101, 15'b1_00_00_0_0_00101_0_0_0);
        add_op("AND", 7'b0001000, 15'b1_00_00_0_0_01000_0_0_0);
        add_op("OR",  7'b0001001, 15'b1_00_00_0_0_01010_0_0_0);
        add_op("XOR", 7'b0001010, 15'b1_00_00_0_0_01100_0_0_0);
        add_op("NOT", 7'b0001011, 15'b1_00_00_0_0_01110_0_0_0);
        add_op("ADI", 7'b0100010, 15'b1_00_00_0_0_00010_1_0_1);
        add_op("SBI", 7'b0100101, 15'b1_00_00_0_0_00101_1_0_1);
        add_op("ANI", 7'b0101000, 15'b1_00_00_0_0_01000_1_0_0);
        add_op("ORI", 7'b0101001, 15'b1_00_00_0_0_01010_1_0_0);
        add_op("XRI", 7'b0101010, 15'b1_00_00_0_0_01100_1_0_0);
        add_op("AIU", 7'b1000010, 15'b1_00_00_0_0_00010_1_0_0);
        add_op("SIU", 7'b1000101, 15'b1_00_00_0_0_00101_1_0_0);
        add_op("LSL", 7'b0001100, 15'b1_00_00_0_0_11000_0_0_0);
        add_op("LSR", 7'b0001101, 15'b1_00_00_0_0_10100_0_0_0);
        add_op("LOD", 7'b0010000, 15'b1_01_00_0_0_00000_0_0_0);
        add_op("ST",  7'b0100000, 15'b0_00_00_0_1_00000_0_0_0);
        add_op("JMR", 7'b1110000, 15'b0_00_10_0_0_00000_0_0_0);
        add_op("SLT", 7'b1100101, 15'b1_10_00_0_0_00101_0_0_0);
        add_op("BZ",  7'b1100000, 15'b0_00_01_0_0_00000_1_0_1);
        add_op("BNZ", 7'b1001000, 15'b0_00_01_1_0_00000_1_0_1);
        add_op("JMP", 7'b1000100, 15'b0_00_11_0_0_00000_1_0_1);
        add_op("JML", 7'b0000111, 15'b1_00_11_0_0_00111_1_1_1);
    endtask

    function automatic logic [31:0] mk(input string name, input logic [4:0] dr, input logic [4:0] sa,
                                       input logic [4:0] sb);
        return {op_of[name], dr, sa, sb, 10'($urandom)};
    endfunction

    function automatic word_t expect_word(input logic [31:0] ins);
        word_t      w;
        logic [6:0] op;
        w       = '0;
        w.valid = 1'b1;
        op      = ins[31:25];
        if (cw_tab.exists(op)) begin
            {w.rw, w.md, w.bs, w.ps, w.mw, w.fs, w.mb, w.ma, w.cs} = cw_tab[op];
            if (op != op_of["NOP"]) begin
                w.da = ins[24:20];
                w.aa = ins[19:15];
                w.ba = ins[14:10];
            end
        end else begin
            w.illegal = 1'b1;
        end
        return w;
    endfunction

    function automatic word_t obs();
        return {out_valid, out_illegal, RW, MW, PS, MA, MB, CS, MD, BS, FS, DA, AA, BA};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick(); tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        in_instr = mk("ADD", 5'd3, 5'd1, 5'd2);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        tick(); tick();
        checks++; if (obs() !== word_t'('0)) begin errors++; $display("FAIL reset_word: got %h want 0", obs()); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
        RESET = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_add();
        logic [31:0] ins;
        do_reset();
        ins = mk("ADD", 5'd3, 5'd1, 5'd2);
        in_instr = ins; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b want 1", in_ready); end
        tick(); in_valid = 1'b0;
        checks++; if (obs() !== expect_word(ins)) begin errors++; $display("FAIL add_word: got %h want %h", obs(), expect_word(ins)); end
        checks++; if (FS !== 5'b00010 || DA !== 5'd3 || AA !== 5'd1 || BA !== 5'd2 || RW !== 1'b1)
            begin errors++; $display("FAIL add_fields: got FS=%b DA=%0d AA=%0d BA=%0d RW=%b want 00010 3 1 2 1", FS, DA, AA, BA, RW); end
    endtask

    task automatic test_load_use();
        logic [31:0] lod, add;
        do_reset();
        lod = mk("LOD", 5'd4, 5'd1, 5'd2);
        add = mk("ADD", 5'd5, 5'd4, 5'd3);
        in_valid = 1'b1; out_ready = 1'b1; in_instr = lod;
        tick();
        in_instr = add; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_ready_hz: got %b want 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b want 0", out_valid); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall: got %0d want 1", stall_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_ready_after: got %b want 1", in_ready); end
        tick(); in_valid = 1'b0;
        checks++; if (obs() !== expect_word(add)) begin errors++; $display("FAIL lu_add_word: got %h want %h", obs(), expect_word(add)); end
    endtask

    task automatic test_no_hazard();
        logic [31:0] lod, add;
        do_reset();
        lod = mk("LOD", 5'd0, 5'd1, 5'd2);
        add = mk("ADD", 5'd5, 5'd0, 5'd0);
        in_valid = 1'b1; out_ready = 1'b1; in_instr = lod;
        tick();
        in_instr = add; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nohz_ready: got %b want 1", in_ready); end
        tick(); in_valid = 1'b0;
        checks++; if (obs() !== expect_word(add)) begin errors++; $display("FAIL nohz_word: got %h want %h", obs(), expect_word(add)); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL nohz_stall: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_hold();
        logic [31:0] jml;
        do_reset();
        jml = mk("JML", 5'd7, 5'd2, 5'd3);
        in_valid = 1'b1; out_ready = 1'b1; in_instr = jml;
        tick();
        out_ready = 1'b0; in_instr = mk("SUB", 5'd1, 5'd9, 5'd9);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b want 0", i, in_ready); end
            tick();
            checks++; if (obs() !== expect_word(jml)) begin errors++; $display("FAIL hold_word[%0d]: got %h want %h", i, obs(), expect_word(jml)); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        logic [31:0] x;
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1; in_instr = mk("SUB", 5'd1, 5'd2, 5'd3);
        tick();
        x = mk("XOR", 5'd6, 5'd7, 5'd8);
        in_instr = x; flush = 1'b1; out_ready = 1'b0; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        flush = 1'b0; out_ready = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after: got %b want 1", in_ready); end
        tick(); in_valid = 1'b0;
        checks++; if (obs() !== expect_word(x)) begin errors++; $display("FAIL flush_word: got %h want %h", obs(), expect_word(x)); end
    endtask

    task automatic test_illegal_reset();
        logic [31:0] ill, bnz;
        do_reset();
        ill = {7'h7F, 25'($urandom)};
        in_valid = 1'b1; out_ready = 1'b1; in_instr = ill;
        tick();
        checks++; if (obs() !== expect_word(ill)) begin errors++; $display("FAIL illegal_word: got %h want %h", obs(), expect_word(ill)); end
        checks++; if (out_illegal !== 1'b1 || RW !== 1'b0 || MW !== 1'b0 || BS !== 2'b00)
            begin errors++; $display("FAIL illegal_bits: got ill=%b RW=%b MW=%b BS=%b want 1 0 0 00", out_illegal, RW, MW, BS); end
        in_instr = mk("ADI", 5'd2, 5'd3, 5'd4);
        tick();
        RESET = 1'b1; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b want 0", in_ready); end
        tick();
        checks++; if (obs() !== word_t'('0) || stall_cnt !== 16'd0)
            begin errors++; $display("FAIL midreset_word: got %h cnt=%0d want 0 0", obs(), stall_cnt); end
        RESET = 1'b0; bnz = mk("BNZ", 5'd1, 5'd2, 5'd3); in_instr = bnz; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL postreset_ready: got %b want 1", in_ready); end
        tick(); in_valid = 1'b0;
        checks++; if (obs() !== expect_word(bnz)) begin errors++; $display("FAIL postreset_word: got %h want %h", obs(), expect_word(bnz)); end
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1; in_instr = mk("LOD", 5'd4, 5'd0, 5'd0);
        tick();
        out_ready = 1'b0; in_instr = mk("ADD", 5'd5, 5'd4, 5'd4);
        repeat (6) tick();
        checks++; if (stall_cnt !== 16'd6) begin errors++; $display("FAIL sat_main: got %0d want 6", stall_cnt); end
        checks++; if (s_stall_cnt !== 2'd3) begin errors++; $display("FAIL sat_small: got %0d want 3", s_stall_cnt); end
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [6:0]  op;
        logic        v, hz, rdy, acc;
        word_t       w;
        int          cnt;
        do_reset();
        v = 1'b0; w = '0; cnt = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            else op = ops[$urandom_range(0, ops.size() - 1)];
            ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 10'($urandom)};
            in_instr  = ins;
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 9) == 0);
            #1;
            hz  = v && w.md == 2'b01 && w.da != 5'd0 && in_valid && (ins[19:15] == w.da || ins[14:10] == w.da);
            rdy = !flush && !hz && (!v || out_ready);
            acc = in_valid && rdy;
            checks++; if (in_ready !== rdy) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, rdy); end
            tick();
            if (hz && cnt < 65535) cnt++;
            if (flush) v = 1'b0;
            else if (acc) begin v = 1'b1; w = expect_word(ins); end
            else if (out_ready) v = 1'b0;
            if (v) begin
                checks++; if (obs() !== w) begin errors++; $display("FAIL rnd_word[%0d]: got %h want %h", i, obs(), w); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want 0", i, out_valid); end
            end
            checks++; if (stall_cnt !== 16'(cnt)) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", i, stall_cnt, cnt); end
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        RESET = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_instr = '0;
        build_table();
        test_reset();
        test_add();
        test_load_use();
        test_no_hazard();
        test_hold();
        test_flush();
        test_illegal_reset();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
